// File: rtl/hybridift_sram_mp.sv
`timescale 1ns/1ps
// hybridift_sram_mp
// Multi-port SRAM wrapper: NUM_PORTS requestors are arbitrated round-robin
// onto one sram_mem array, writes use per-byte enables, and read data returns
// READ_LATENCY cycles after the grant on the requesting port.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/we_i             per-port request and write flag
//   addr_i/wdata_i/be_i    per-port payload, port p at [p*W +: W]
//   gnt_o                  one-hot combinational grant
//   rvalid_o/rdata_o       per-port read return (rdata 0 when not valid)
//   mem_*_o                memory tap for DPI / taint monitors

// Word-addressed array with a registered read port (1-cycle read).
module sram_mem #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 1 << 17,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] strb_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (req_i) begin
            if (we_i) begin
                mem[addr_i] <= (mem[addr_i] & ~strb_i) | (wdata_i & strb_i);
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end
endmodule

module hybridift_sram_mp #(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 1 << 17,
    parameter int READ_LATENCY = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_PORTS-1:0]                 req_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS*$clog2(DEPTH)-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      wdata_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  be_i,
    output logic [NUM_PORTS-1:0]                 gnt_o,
    output logic [NUM_PORTS-1:0]                 rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]      rdata_o,
    output logic                                 mem_req_o,
    output logic [$clog2(DEPTH)-1:0]             mem_addr_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    output logic [DATA_WIDTH-1:0]                mem_strb_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH-1:0]                mem_rdata_o,
    output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] mem_port_o
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;
    localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PORT_W-1:0]     prio;
    logic [PORT_W-1:0]     prio_nxt;
    logic [PORT_W-1:0]     gnt_idx;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] addr_g;
    logic [DATA_WIDTH-1:0] wdata_g;
    logic [BE_WIDTH-1:0]   be_g;
    logic                  we_g;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] rdata_out;

    logic                  vld_p  [READ_LATENCY];
    logic [PORT_W-1:0]     port_p [READ_LATENCY];

    // Round-robin search starting at prio; the grant is masked while in reset.
    always_comb begin
        int sum;
        sum     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = int'(prio) + i;
            if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
            if (!gnt_any && req_i[PORT_W'(sum)]) begin
                gnt_any = 1'b1;
                gnt_idx = PORT_W'(sum);
            end
        end
        if (!rst_ni) begin
            gnt_any = 1'b0;
            gnt_idx = '0;
        end
    end

    assign gnt_o    = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;
    assign prio_nxt = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PORT_W'(1);

    // Granted payload mux and memory tap.
    always_comb begin
        addr_g      = addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_g     = wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        be_g        = be_i[gnt_idx*BE_WIDTH +: BE_WIDTH];
        we_g        = we_i[gnt_idx];
        mem_wr      = gnt_any && we_g;
        mem_req_o   = gnt_any;
        mem_addr_o  = gnt_any ? addr_g : addr_hold;
        mem_wdata_o = gnt_any ? wdata_g : '0;
        mem_strb_o  = '0;
        for (int b = 0; b < BE_WIDTH; b++) begin
            mem_strb_o[b*8 +: 8] = {8{mem_wr && be_g[b]}};
        end
        mem_we_o    = |mem_strb_o;
        mem_port_o  = gnt_idx;
    end

    sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram_mem (
        .clk_i   (clk_i),
        .req_i   (gnt_any),
        .we_i    (mem_wr),
        .addr_i  (mem_addr_o),
        .wdata_i (mem_wdata_o),
        .strb_i  (mem_strb_o),
        .rdata_o (mem_rdata_o)
    );

    // Stage p0: grant registered into the {port, valid} return pipeline.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio      <= '0;
            addr_hold <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                port_p[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                prio      <= prio_nxt;
                addr_hold <= addr_g;
            end
            vld_p[0]  <= gnt_any && !we_g;
            port_p[0] <= gnt_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                port_p[i] <= port_p[i-1];
            end
        end
    end

    // Stages p1..: extra data registers beyond the array's own read register.
    if (READ_LATENCY > 1) begin : g_dpipe
        logic [DATA_WIDTH-1:0] rdata_p [READ_LATENCY-1];
        always_ff @(posedge clk_i) begin
            rdata_p[0] <= mem_rdata_o;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                rdata_p[i] <= rdata_p[i-1];
            end
        end
        assign rdata_out = rdata_p[READ_LATENCY-2];
    end else begin : g_nopipe
        assign rdata_out = mem_rdata_o;
    end

    // Return stage: steer the exiting entry to its port, zero elsewhere.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst_ni && vld_p[READ_LATENCY-1] && port_p[READ_LATENCY-1] == PORT_W'(p)) begin
                rvalid_o[p]                    = 1'b1;
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_out;
            end
        end
    end
endmodule
